uart_rx_cmd_parser: RTL and testbench
=====================================

Name: uart_rx_cmd_parser

Overview:
Consumes the byte stream from the UART receiver (parallel byte, valid pulse, parity/stop error flags) and decodes multi-byte command frames. It drives register-file write/read requests and ALU operations, then returns read/ALU results to the UART transmit path through a valid/ready byte handshake. It sits between the UART receiver and the register file, ALU and UART transmitter.

Parameters:
ADDR_WIDTH, 4, register-file address width; the address byte is truncated to its low ADDR_WIDTH bits
TIMEOUT_CYC, 255, maximum CLK cycles to wait for RdData_Valid or ALU_OUT_VLD before the frame is aborted

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  8  received byte
RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA and the error flags are valid
PAR_ERROR  in  1  parity error for the current byte
STP_ERROR  in  1  stop error for the current byte
WrEn  out  1  register-file write strobe, one cycle
RdEn  out  1  register-file read strobe, one cycle
Address  out  ADDR_WIDTH  register-file address
WrData  out  8  register-file write data
RdData  in  8  register-file read data
RdData_Valid  in  1  RdData valid pulse
ALU_EN  out  1  ALU start strobe, one cycle
ALU_FUN  out  4  ALU function code
ALU_OUT  in  16  ALU result
ALU_OUT_VLD  in  1  ALU result valid pulse
TX_P_DATA  out  8  byte to the transmitter
TX_D_VLD  out  1  byte valid; held until accepted
TX_READY  in  1  transmitter can accept a byte
FRAME_ERR  out  1  one-cycle pulse: a byte arrived with a parity or stop error
CMD_ERR  out  1  one-cycle pulse: unknown opcode or response timeout
OVERRUN  out  1  one-cycle pulse: a byte arrived while the FSM was busy

Behaviour:
- Reset: every output is 0, the FSM is in IDLE and the timeout counter is 0. Reset takes effect immediately at any point, including mid-frame, and aborts the frame.
- All outputs are registered. Every strobe rises in the cycle after the RX_D_VLD or response pulse that causes it.
- Opcodes received in IDLE:
  - 0xAA goes to WR_ADDR.
  - 0xBB goes to RD_ADDR.
  - 0xCC goes to ALU_A.
  - 0xDD goes to ALU_FUN.
  - Any other byte pulses CMD_ERR and the FSM stays in IDLE.
- WR_ADDR: the byte is latched as Address, then the FSM goes to WR_DATA.
- WR_DATA: drives WrData = byte and pulses WrEn, then returns to IDLE.
- RD_ADDR: latches Address, pulses RdEn, then goes to RD_WAIT.
- RD_WAIT: on RdData_Valid, latches RdData into TX byte 0 and goes to TX0.
- ALU_A: writes the byte to Address 0 (WrEn pulse), then goes to ALU_B.
- ALU_B: writes the byte to Address 1 (WrEn pulse), then goes to ALU_FUN.
- ALU_FUN: ALU_FUN = byte[3:0] and ALU_EN pulses, then the FSM goes to ALU_WAIT.
- ALU_WAIT: on ALU_OUT_VLD, latches ALU_OUT. TX0 carries ALU_OUT[7:0] and TX1 carries ALU_OUT[15:8], LSB first.
- TX0 / TX1: TX_D_VLD is high with TX_P_DATA stable. A transfer completes in a cycle where TX_D_VLD and TX_READY are both high. TX0 then goes to TX1 (ALU result) or to IDLE (read result); TX1 goes to IDLE. TX_D_VLD drops in the cycle after the final transfer.
- Timeout:
  - The counter clears on entry to RD_WAIT or ALU_WAIT and increments each cycle while in those states.
  - When it reaches TIMEOUT_CYC without a response, CMD_ERR pulses and the FSM returns to IDLE.
  - A response arriving in the same cycle as the terminal count is accepted and no CMD_ERR is raised.
- Error byte: RX_D_VLD with PAR_ERROR or STP_ERROR high in any byte-collecting state (IDLE, WR_*, RD_ADDR, ALU_A/B/FUN) discards the byte, pulses FRAME_ERR and returns to IDLE. No WrEn, RdEn or ALU_EN is issued for that frame. Earlier operand writes from the same frame are not undone.
- Busy states: RX_D_VLD in RD_WAIT, ALU_WAIT, TX0 or TX1 drops the byte and pulses OVERRUN; the FSM is unaffected.
- Unsolicited responses: RdData_Valid or ALU_OUT_VLD outside its wait state is ignored.

Test Plan:
1. Bytes AA, 05, 3C -> one WrEn pulse with Address=5 and WrData=0x3C; no other strobes.
2. Bytes BB, 02; RdData=0x77 with RdData_Valid 3 cycles after RdEn; TX_READY low for 4 cycles, then high -> RdEn with Address=2, then TX_D_VLD held with TX_P_DATA=0x77 until accepted, then IDLE.
3. Bytes CC, 10, 20, 01; ALU_OUT=0x1234 -> WrEn at Address 0 (0x10), WrEn at Address 1 (0x20), ALU_EN with ALU_FUN=1, then TX bytes 0x34 then 0x12.
4. Bytes AA, 05, then the data byte arriving with PAR_ERROR=1 -> FRAME_ERR pulse, no WrEn. A following valid DD, 03 frame executes normally.
5. Bytes BB, 01 with no RdData_Valid -> CMD_ERR exactly TIMEOUT_CYC cycles after RD_WAIT entry; a byte 0x55 injected during RD_WAIT pulses OVERRUN; unknown opcode 0x12 in IDLE pulses CMD_ERR.
6. RST asserted during ALU_WAIT and during TX1 -> all outputs 0 at once; after release, AA 00 FF performs a normal write.

Source files
------------

// File: rtl/uart_rx_cmd_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cmd_parser_if
// Brief    : Byte-stream, register-file, ALU and TX handshake bundle for the
//            UART command parser.
// Revision : 1.0  initial release
// ============================================================================
interface uart_rx_cmd_parser_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [7:0]            RX_P_DATA;
    logic                  RX_D_VLD;
    logic                  PAR_ERROR;
    logic                  STP_ERROR;
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [7:0]            WrData;
    logic [7:0]            RdData;
    logic                  RdData_Valid;
    logic                  ALU_EN;
    logic [3:0]            ALU_FUN;
    logic [15:0]           ALU_OUT;
    logic                  ALU_OUT_VLD;
    logic [7:0]            TX_P_DATA;
    logic                  TX_D_VLD;
    logic                  TX_READY;
    logic                  FRAME_ERR;
    logic                  CMD_ERR;
    logic                  OVERRUN;

    // Parser side
    modport master (
        input  RX_P_DATA, RX_D_VLD, PAR_ERROR, STP_ERROR,
        input  RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, TX_READY,
        output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN,
        output TX_P_DATA, TX_D_VLD, FRAME_ERR, CMD_ERR, OVERRUN
    );

    // Environment side: UART RX/TX, register file and ALU
    modport slave (
        output RX_P_DATA, RX_D_VLD, PAR_ERROR, STP_ERROR,
        output RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, TX_READY,
        input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN,
        input  TX_P_DATA, TX_D_VLD, FRAME_ERR, CMD_ERR, OVERRUN
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cmd_parser
// Brief    : Decodes UART command frames into register-file / ALU operations
//            and returns read or ALU results as TX bytes.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_cmd_parser #(
    parameter int ADDR_WIDTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  wire logic              CLK,
    input  wire logic              RST,
    uart_rx_cmd_parser_if.master   bus
);
    localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_term_cnt = c_cnt_w'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
        S_ALU_A, S_ALU_B, S_ALU_FUN, S_ALU_WAIT, S_TX0, S_TX1
    } state_t;

    state_t                r_state,     w_state_nxt;
    logic                  r_wr_en,     w_wr_en;
    logic                  r_rd_en,     w_rd_en;
    logic                  r_alu_en,    w_alu_en;
    logic                  r_frame_err, w_frame_err;
    logic                  r_cmd_err,   w_cmd_err;
    logic                  r_overrun,   w_overrun;
    logic                  r_tx_vld,    w_tx_vld;
    logic                  r_tx_two,    w_tx_two;
    logic [ADDR_WIDTH-1:0] r_addr,      w_addr;
    logic [7:0]            r_wr_data,   w_wr_data;
    logic [3:0]            r_alu_fun,   w_alu_fun;
    logic [7:0]            r_tx_data,   w_tx_data;
    logic [7:0]            r_tx_hi,     w_tx_hi;
    logic [c_cnt_w-1:0]    r_cnt,       w_cnt;

    logic w_rx_bad;
    logic w_collecting;

    assign w_rx_bad     = bus.RX_D_VLD && (bus.PAR_ERROR || bus.STP_ERROR);
    assign w_collecting = (r_state inside {S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR,
                                           S_ALU_A, S_ALU_B, S_ALU_FUN});

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_alu_en    <= 1'b0;
            r_frame_err <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_overrun   <= 1'b0;
            r_tx_vld    <= 1'b0;
            r_tx_two    <= 1'b0;
            r_addr      <= '0;
            r_wr_data   <= '0;
            r_alu_fun   <= '0;
            r_tx_data   <= '0;
            r_tx_hi     <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_en     <= w_wr_en;
            r_rd_en     <= w_rd_en;
            r_alu_en    <= w_alu_en;
            r_frame_err <= w_frame_err;
            r_cmd_err   <= w_cmd_err;
            r_overrun   <= w_overrun;
            r_tx_vld    <= w_tx_vld;
            r_tx_two    <= w_tx_two;
            r_addr      <= w_addr;
            r_wr_data   <= w_wr_data;
            r_alu_fun   <= w_alu_fun;
            r_tx_data   <= w_tx_data;
            r_tx_hi     <= w_tx_hi;
            r_cnt       <= w_cnt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_alu_en    = 1'b0;
        w_frame_err = 1'b0;
        w_cmd_err   = 1'b0;
        w_overrun   = 1'b0;
        w_tx_vld    = r_tx_vld;
        w_tx_two    = r_tx_two;
        w_addr      = r_addr;
        w_wr_data   = r_wr_data;
        w_alu_fun   = r_alu_fun;
        w_tx_data   = r_tx_data;
        w_tx_hi     = r_tx_hi;
        w_cnt       = r_cnt;

        // A corrupted byte kills the frame; operand writes already issued stay.
        if (w_collecting && w_rx_bad) begin
            w_frame_err = 1'b1;
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (bus.RX_D_VLD) begin
                    case (bus.RX_P_DATA)
                        8'hAA:   w_state_nxt = S_WR_ADDR;
                        8'hBB:   w_state_nxt = S_RD_ADDR;
                        8'hCC:   w_state_nxt = S_ALU_A;
                        8'hDD:   w_state_nxt = S_ALU_FUN;
                        default: w_cmd_err   = 1'b1;
                    endcase
                end
                S_WR_ADDR: if (bus.RX_D_VLD) begin
                    w_addr      = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    w_state_nxt = S_WR_DATA;
                end
                S_WR_DATA: if (bus.RX_D_VLD) begin
                    w_wr_data   = bus.RX_P_DATA;
                    w_wr_en     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_RD_ADDR: if (bus.RX_D_VLD) begin
                    w_addr      = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    w_rd_en     = 1'b1;
                    w_cnt       = '0;
                    w_state_nxt = S_RD_WAIT;
                end
                S_ALU_A: if (bus.RX_D_VLD) begin
                    w_addr      = '0;
                    w_wr_data   = bus.RX_P_DATA;
                    w_wr_en     = 1'b1;
                    w_state_nxt = S_ALU_B;
                end
                S_ALU_B: if (bus.RX_D_VLD) begin
                    w_addr      = ADDR_WIDTH'(1);
                    w_wr_data   = bus.RX_P_DATA;
                    w_wr_en     = 1'b1;
                    w_state_nxt = S_ALU_FUN;
                end
                S_ALU_FUN: if (bus.RX_D_VLD) begin
                    w_alu_fun   = bus.RX_P_DATA[3:0];
                    w_alu_en    = 1'b1;
                    w_cnt       = '0;
                    w_state_nxt = S_ALU_WAIT;
                end
                // A response on the terminal-count cycle still wins over the timeout.
                S_RD_WAIT: begin
                    w_overrun = bus.RX_D_VLD;
                    w_cnt     = r_cnt + c_cnt_w'(1);
                    if (bus.RdData_Valid) begin
                        w_tx_data   = bus.RdData;
                        w_tx_two    = 1'b0;
                        w_tx_vld    = 1'b1;
                        w_state_nxt = S_TX0;
                    end else if (r_cnt == c_term_cnt) begin
                        w_cmd_err   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_ALU_WAIT: begin
                    w_overrun = bus.RX_D_VLD;
                    w_cnt     = r_cnt + c_cnt_w'(1);
                    if (bus.ALU_OUT_VLD) begin
                        w_tx_data   = bus.ALU_OUT[7:0];
                        w_tx_hi     = bus.ALU_OUT[15:8];
                        w_tx_two    = 1'b1;
                        w_tx_vld    = 1'b1;
                        w_state_nxt = S_TX0;
                    end else if (r_cnt == c_term_cnt) begin
                        w_cmd_err   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_TX0: begin
                    w_overrun = bus.RX_D_VLD;
                    if (bus.TX_READY) begin
                        if (r_tx_two) begin
                            w_tx_data   = r_tx_hi;
                            w_state_nxt = S_TX1;
                        end else begin
                            w_tx_vld    = 1'b0;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_TX1: begin
                    w_overrun = bus.RX_D_VLD;
                    if (bus.TX_READY) begin
                        w_tx_vld    = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.WrEn      = r_wr_en;
    assign bus.RdEn      = r_rd_en;
    assign bus.Address   = r_addr;
    assign bus.WrData    = r_wr_data;
    assign bus.ALU_EN    = r_alu_en;
    assign bus.ALU_FUN   = r_alu_fun;
    assign bus.TX_P_DATA = r_tx_data;
    assign bus.TX_D_VLD  = r_tx_vld;
    assign bus.FRAME_ERR = r_frame_err;
    assign bus.CMD_ERR   = r_cmd_err;
    assign bus.OVERRUN   = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cmd_parser
// Brief    : Randomised frame-level bench for uart_rx_cmd_parser with a
//            queue scoreboard fed by a transaction model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_cmd_parser;
    localparam int AW = 4;
    localparam int TO = 20;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   cyc = 0;

    uart_rx_cmd_parser_if #(.ADDR_WIDTH(AW)) bus ();

    uart_rx_cmd_parser #(.ADDR_WIDTH(AW), .TIMEOUT_CYC(TO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { int cyc; int a; int d; } ev_t;
    ev_t q_wr[$], q_rd[$], q_alu[$], q_fe[$], q_ce[$], q_ov[$], q_tx[$];

    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 0;   // 0 random, 1 forced low, 2 forced high
    int hold_cyc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic unexp(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: strobe got=1 expected=0 (cycle %0d)", name, cyc);
    endtask

    function automatic ev_t mk(input int c, input int a, input int d);
        ev_t e;
        e.cyc = c; e.a = a; e.d = d;
        return e;
    endfunction

    // ---------------- monitor ----------------
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge CLK) begin
        ev_t e;
        if (!RST) begin
            prev_hold = 1'b0;
        end else begin
            if (bus.WrEn) begin
                if (q_wr.size() == 0) unexp("WrEn");
                else begin
                    e = q_wr.pop_front();
                    chk("WrEn_cycle", cyc, e.cyc);
                    chk("WrEn_Address", 32'(bus.Address), e.a);
                    chk("WrEn_WrData", 32'(bus.WrData), e.d);
                end
            end
            if (bus.RdEn) begin
                if (q_rd.size() == 0) unexp("RdEn");
                else begin
                    e = q_rd.pop_front();
                    chk("RdEn_cycle", cyc, e.cyc);
                    chk("RdEn_Address", 32'(bus.Address), e.a);
                end
            end
            if (bus.ALU_EN) begin
                if (q_alu.size() == 0) unexp("ALU_EN");
                else begin
                    e = q_alu.pop_front();
                    chk("ALU_EN_cycle", cyc, e.cyc);
                    chk("ALU_FUN", 32'(bus.ALU_FUN), e.a);
                end
            end
            if (bus.FRAME_ERR) begin
                if (q_fe.size() == 0) unexp("FRAME_ERR");
                else begin e = q_fe.pop_front(); chk("FRAME_ERR_cycle", cyc, e.cyc); end
            end
            if (bus.CMD_ERR) begin
                if (q_ce.size() == 0) unexp("CMD_ERR");
                else begin e = q_ce.pop_front(); chk("CMD_ERR_cycle", cyc, e.cyc); end
            end
            if (bus.OVERRUN) begin
                if (q_ov.size() == 0) unexp("OVERRUN");
                else begin e = q_ov.pop_front(); chk("OVERRUN_cycle", cyc, e.cyc); end
            end
            if (prev_hold) begin
                chk("TX_hold_valid", 32'(bus.TX_D_VLD), 1);
                chk("TX_hold_data", 32'(bus.TX_P_DATA), 32'(prev_data));
            end
            if (bus.TX_D_VLD && bus.TX_READY) begin
                if (q_tx.size() == 0) unexp("TX_transfer");
                else begin e = q_tx.pop_front(); chk("TX_P_DATA", 32'(bus.TX_P_DATA), e.d); end
            end
            prev_hold = bus.TX_D_VLD && !bus.TX_READY;
            prev_data = bus.TX_P_DATA;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
        case (rdy_mode)
            0:       bus.TX_READY = ($urandom_range(0, 2) != 0);
            1:       bus.TX_READY = 1'b0;
            default: bus.TX_READY = 1'b1;
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b, input logic pe, input logic se);
        bus.RX_P_DATA = b;
        bus.PAR_ERROR = pe;
        bus.STP_ERROR = se;
        bus.RX_D_VLD  = 1'b1;
        tick();
        bus.RX_D_VLD  = 1'b0;
        bus.PAR_ERROR = 1'b0;
        bus.STP_ERROR = 1'b0;
        bus.RX_P_DATA = 8'($urandom);
    endtask

    // Idle gap between bytes; sometimes with stray responses that must be ignored.
    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.RdData       = 8'($urandom);
                bus.RdData_Valid = 1'b1;
                bus.ALU_OUT      = 16'($urandom);
                bus.ALU_OUT_VLD  = $urandom_range(0, 1) == 1;
            end
            tick();
            bus.RdData_Valid = 1'b0;
            bus.ALU_OUT_VLD  = 1'b0;
        end
    endtask

    // kind: 0 write(p0 addr, p1 data) 1 read(p0) 2 alu(p0,p1,p2) 3 fun-only(p0) 4 raw opcode p0
    // resp_k: cycles after wait entry; TO means one cycle too late, >TO means never.
    task automatic run_frame(input int kind, input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input int err_idx, input int resp_k,
                             input int ovr_j, input logic [15:0] resp, input bit tx_ovr);
        logic [7:0] bytes [4];
        int         nb;
        int         entry;
        int         n;
        bit         acc;
        logic       pe;
        case (kind)
            0:       begin bytes[0] = 8'hAA; bytes[1] = p0; bytes[2] = p1; nb = 3; end
            1:       begin bytes[0] = 8'hBB; bytes[1] = p0; nb = 2; end
            2:       begin bytes[0] = 8'hCC; bytes[1] = p0; bytes[2] = p1; bytes[3] = p2; nb = 4; end
            3:       begin bytes[0] = 8'hDD; bytes[1] = p0; nb = 2; end
            default: begin bytes[0] = p0; nb = 1; end
        endcase
        for (int i = 0; i < nb; i++) begin
            gap();
            if (i == err_idx) begin
                q_fe.push_back(mk(cyc + 1, 0, 0));
                pe = $urandom_range(0, 1) == 1;
                send_byte(bytes[i], pe, pe ? ($urandom_range(0, 1) == 1) : 1'b1);
                return;
            end
            if (kind == 0 && i == 2) q_wr.push_back(mk(cyc + 1, int'(p0) % (1 << AW), int'(p1)));
            if (kind == 1 && i == 1) q_rd.push_back(mk(cyc + 1, int'(p0) % (1 << AW), 0));
            if (kind == 2 && i == 1) q_wr.push_back(mk(cyc + 1, 0, int'(p0)));
            if (kind == 2 && i == 2) q_wr.push_back(mk(cyc + 1, 1, int'(p1)));
            if (kind == 2 && i == 3) q_alu.push_back(mk(cyc + 1, int'(p2) % 16, 0));
            if (kind == 3 && i == 1) q_alu.push_back(mk(cyc + 1, int'(p0) % 16, 0));
            if (kind == 4)           q_ce.push_back(mk(cyc + 1, 0, 0));
            send_byte(bytes[i], 1'b0, 1'b0);
        end
        if (kind == 0 || kind == 4) return;

        entry = cyc;
        acc   = 1'b0;
        if (resp_k >= TO) q_ce.push_back(mk(entry + TO, 0, 0));
        for (int t = 0; t < TO; t++) begin
            if (t == ovr_j) begin
                q_ov.push_back(mk(cyc + 1, 0, 0));
                bus.RX_P_DATA = 8'h55;
                bus.PAR_ERROR = $urandom_range(0, 1) == 1;
                bus.RX_D_VLD  = 1'b1;
            end
            if (t == resp_k) begin
                if (kind == 1) begin bus.RdData = resp[7:0]; bus.RdData_Valid = 1'b1; end
                else begin bus.ALU_OUT = resp; bus.ALU_OUT_VLD = 1'b1; end
                acc = 1'b1;
            end
            tick();
            bus.RX_D_VLD     = 1'b0;
            bus.PAR_ERROR    = 1'b0;
            bus.RdData_Valid = 1'b0;
            bus.ALU_OUT_VLD  = 1'b0;
            if (acc) break;
        end
        if (!acc) begin
            if (resp_k == TO) begin
                if (kind == 1) bus.RdData_Valid = 1'b1; else bus.ALU_OUT_VLD = 1'b1;
                tick();
                bus.RdData_Valid = 1'b0;
                bus.ALU_OUT_VLD  = 1'b0;
            end
            return;
        end

        q_tx.push_back(mk(-1, 0, int'(resp[7:0])));
        if (kind != 1) q_tx.push_back(mk(-1, 0, int'(resp[15:8])));
        if (hold_cyc > 0) begin
            rdy_mode     = 1;
            bus.TX_READY = 1'b0;
            repeat (hold_cyc) tick();
            rdy_mode     = 2;
        end
        if (tx_ovr) begin
            q_ov.push_back(mk(cyc + 1, 0, 0));
            send_byte(8'($urandom), 1'b0, 1'b0);
        end
        n = 0;
        while (bus.TX_D_VLD && n < 200) begin
            tick();
            n++;
        end
        chk("TX_drain", 32'(bus.TX_D_VLD), 0);
        rdy_mode = 0;
    endtask

    task automatic apply_reset(input string tag);
        RST = 1'b0;
        #1;
        chk(tag, {bus.WrEn, bus.RdEn, bus.Address, bus.WrData, bus.ALU_EN, bus.ALU_FUN,
                  bus.TX_P_DATA, bus.TX_D_VLD, bus.FRAME_ERR, bus.CMD_ERR, bus.OVERRUN}, 0);
        q_wr.delete(); q_rd.delete(); q_alu.delete(); q_fe.delete();
        q_ce.delete(); q_ov.delete(); q_tx.delete();
        repeat (2) tick();
        RST = 1'b1;
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         kind, nb, err, rk, oj;
        logic [7:0] op;
        bus.RX_P_DATA = '0; bus.RX_D_VLD = 1'b0; bus.PAR_ERROR = 1'b0; bus.STP_ERROR = 1'b0;
        bus.RdData = '0; bus.RdData_Valid = 1'b0; bus.ALU_OUT = '0; bus.ALU_OUT_VLD = 1'b0;
        bus.TX_READY = 1'b0;
        repeat (3) tick();
        apply_reset("reset_outputs");

        run_frame(0, 8'h05, 8'h3C, 8'h00, -1, 0, -1, 16'h0, 1'b0);
        hold_cyc = 4;
        run_frame(1, 8'h02, 8'h00, 8'h00, -1, 3, -1, 16'h0077, 1'b0);
        hold_cyc = 0;
        run_frame(2, 8'h10, 8'h20, 8'h01, -1, 4, -1, 16'h1234, 1'b0);
        run_frame(0, 8'h05, 8'h3C, 8'h00, 2, 0, -1, 16'h0, 1'b0);
        run_frame(3, 8'h03, 8'h00, 8'h00, -1, 2, -1, 16'hA5C3, 1'b0);
        run_frame(1, 8'h01, 8'h00, 8'h00, -1, TO + 5, 4, 16'h0, 1'b0);
        run_frame(4, 8'h12, 8'h00, 8'h00, -1, 0, -1, 16'h0, 1'b0);
        run_frame(1, 8'h1A, 8'h00, 8'h00, -1, TO - 1, TO - 1, 16'h003D, 1'b0);
        run_frame(3, 8'h07, 8'h00, 8'h00, -1, TO, -1, 16'h4321, 1'b0);
        run_frame(2, 8'h11, 8'h22, 8'h3F, 3, 0, -1, 16'h0, 1'b0);

        // reset while waiting for the ALU
        send_byte(8'hCC, 1'b0, 1'b0);
        q_wr.push_back(mk(cyc + 1, 0, 8'h5A));  send_byte(8'h5A, 1'b0, 1'b0);
        q_wr.push_back(mk(cyc + 1, 1, 8'hA5));  send_byte(8'hA5, 1'b0, 1'b0);
        q_alu.push_back(mk(cyc + 1, 8'h0B, 0)); send_byte(8'h0B, 1'b0, 1'b0);
        repeat (3) tick();
        apply_reset("reset_in_alu_wait");

        // reset while the high result byte is being offered
        rdy_mode = 1;
        send_byte(8'hCC, 1'b0, 1'b0);
        q_wr.push_back(mk(cyc + 1, 0, 8'h01));  send_byte(8'h01, 1'b0, 1'b0);
        q_wr.push_back(mk(cyc + 1, 1, 8'h02));  send_byte(8'h02, 1'b0, 1'b0);
        q_alu.push_back(mk(cyc + 1, 8'h06, 0)); send_byte(8'h06, 1'b0, 1'b0);
        tick();
        bus.ALU_OUT = 16'hBEEF; bus.ALU_OUT_VLD = 1'b1;
        tick();
        bus.ALU_OUT_VLD = 1'b0;
        q_tx.push_back(mk(-1, 0, 8'hEF));
        q_tx.push_back(mk(-1, 0, 8'hBE));
        chk("tx0_valid", 32'(bus.TX_D_VLD), 1);
        rdy_mode = 2; tick();
        rdy_mode = 1; tick();
        chk("tx1_valid", 32'(bus.TX_D_VLD), 1);
        chk("tx1_data", 32'(bus.TX_P_DATA), 32'h0BE);
        apply_reset("reset_in_tx1");
        rdy_mode = 0;
        run_frame(0, 8'h00, 8'hFF, 8'h00, -1, 0, -1, 16'h0, 1'b0);

        for (int f = 0; f < 200; f++) begin
            kind = $urandom_range(0, 4);
            op   = 8'($urandom);
            while (kind == 4 && (op == 8'hAA || op == 8'hBB || op == 8'hCC || op == 8'hDD))
                op = 8'($urandom);
            nb   = (kind == 0) ? 3 : (kind == 2) ? 4 : (kind == 4) ? 1 : 2;
            err  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nb - 1) : -1;
            case ($urandom_range(0, 7))
                0:       rk = TO;
                1:       rk = TO - 1;
                2:       rk = TO + 1;
                default: rk = $urandom_range(0, 8);
            endcase
            oj = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (rk < TO) ? rk : TO - 1) : -1;
            run_frame(kind, (kind == 4) ? op : 8'($urandom), 8'($urandom), 8'($urandom),
                      err, rk, oj, 16'($urandom), $urandom_range(0, 4) == 0);
        end

        repeat (5) tick();
        chk("pending_WrEn", q_wr.size(), 0);
        chk("pending_RdEn", q_rd.size(), 0);
        chk("pending_ALU_EN", q_alu.size(), 0);
        chk("pending_FRAME_ERR", q_fe.size(), 0);
        chk("pending_CMD_ERR", q_ce.size(), 0);
        chk("pending_OVERRUN", q_ov.size(), 0);
        chk("pending_TX", q_tx.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
